serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

- Shares the single serial transmitter (`ser_tx_data` / `ser_new_tx_data` / `ser_tx_busy`) between `NUM_REQ` byte-stream requesters, e.g. the register-access comms block and debug/telemetry streamers.
- Arbitration is packet-granular round-robin: once granted, a requester owns the transmitter until it sends its last byte, drops its request, or stalls past a timeout.
- Sits between the requesters and the serial TX core, and enforces the one-cycle gap the TX core needs before its busy flag is valid.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `WORD_SIZE`, 8, bits per serial byte
- `TIMEOUT`, 1024, stall cycles before a grant is revoked; 0 disables the timeout

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req`  in  NUM_REQ  level request per requester; held for a whole packet
- `req_data`  in  WORD_SIZE*NUM_REQ  byte per requester; requester i uses bits [i*WORD_SIZE +: WORD_SIZE]
- `req_valid`  in  NUM_REQ  byte presented by requester i
- `req_last`  in  NUM_REQ  presented byte is the final byte of the packet
- `req_ready`  out  NUM_REQ  combinational; byte accepted this cycle when valid&ready
- `grant`  out  NUM_REQ  registered, one-hot or zero
- `ser_tx_data`  out  WORD_SIZE  byte to the TX core
- `ser_new_tx_data`  out  1  one-cycle strobe to the TX core
- `ser_tx_busy`  in  1  TX core busy
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout
- `timeout_id`  out  $clog2(NUM_REQ)  index of the revoked requester; holds until the next timeout

## Operation
- FSM states:
  - IDLE: if any `req` bit is set, select the first set bit scanning from `last_grant+1` upward, wrapping at NUM_REQ. Register `grant` for it, record `last_grant`, clear `stall_cnt`, go to ACTIVE. If no `req` bit is set, stay in IDLE.
  - ACTIVE (granted index g): `req_ready[g] = ~ser_tx_busy`; every other `req_ready` bit is 0. Transitions are evaluated in this priority order:
    - `req[g]` low: abort. Clear `grant`, go to IDLE. No byte is taken, even if `req_valid[g]` is high.
    - Transfer (`req_valid[g] & req_ready[g]`): register `req_data` slice g into `ser_tx_data` and pulse `ser_new_tx_data` the next cycle. Clear `stall_cnt`. If `req_last[g]` is set, clear `grant` and go to IDLE; otherwise go to GAP.
    - `~ser_tx_busy & ~req_valid[g]`: increment `stall_cnt`. When the incremented value equals TIMEOUT (and TIMEOUT≠0), clear `grant`, pulse `timeout_err`, load `timeout_id = g`, go to IDLE.
    - Cycles with `ser_tx_busy` high do not count toward the timeout.
  - GAP: one cycle; all `req_ready` bits 0; go to ACTIVE.
  - Illegal state encodings go to IDLE.
- `last_grant` resets to NUM_REQ-1, so requester 0 wins the first arbitration.
- `stall_cnt` is $clog2(TIMEOUT+1) bits wide and never wraps.
- Requests arriving while another requester is granted wait. Their `req_ready` bits stay 0.
- `ser_tx_data` returns to 0 on every cycle with no strobe.

## Timing
- Reset (asynchronous, `rst_n` low): FSM to IDLE. `grant`=0, `req_ready`=0, `ser_tx_data`=0, `ser_new_tx_data`=0, `timeout_err`=0, `timeout_id`=0, `stall_cnt`=0.
- Reset mid-packet drops the packet without emitting a strobe.
- Latency and pacing:
  - `req` rising in IDLE at cycle t → `grant` high at t+1 → earliest transfer at t+1.
  - Transfer at cycle t → `ser_new_tx_data` high at t+1, ACTIVE again at t+2 (GAP covers the TX core's busy latency).
  - Maximum throughput is one byte per 2 cycles, further limited by `ser_tx_busy`.
  - Handover: last byte at t → IDLE at t+1 → next `grant` at t+2.
- Handshake rules:
  - A requester must hold `req_data` and `req_last` stable while `req_valid` is high and `req_ready` is low.
  - `req_ready` for an ungranted requester is always 0.
- Simultaneous events:
  - `req_valid[g]` with `req[g]` low: the abort wins; the byte is not taken.
  - Stall reaching TIMEOUT on the same cycle a byte arrives: the transfer wins and the counter clears.

## Test plan
- Single requester, 3-byte packet (0xA1, 0xB2, 0xC3 with last on 0xC3), `ser_tx_busy` held 0:
  - strobes at t+2, t+4, t+6 (t = `req` rising edge) carrying those bytes in order;
  - `grant` drops the cycle after 0xC3 is accepted.
- All 4 requesters request continuously with 1-byte packets:
  - grants go 0,1,2,3,0 in that order;
  - `grant` is never multi-hot.
- Requester 1 granted while `ser_tx_busy` is held high for 50 cycles with valid asserted:
  - `req_ready[1]`=0 throughout; no strobe; `timeout_err` never pulses;
  - byte goes out 1 cycle after busy falls.
- TIMEOUT=8, requester 2 granted with `req_valid` low and busy low:
  - `timeout_err` pulses on the 8th stall cycle with `timeout_id`=2;
  - `grant` clears; requester 3 is granted next.
- Requester 0 drops `req` mid-packet after 1 byte: grant is released, no further strobes, requester 1 is granted 2 cycles later.
- `rst_n` asserted asynchronously between clock edges while a strobe is pending: all outputs are 0 immediately; no strobe after release.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one serial TX core
// between NUM_REQ byte-stream requesters, with stall timeout.
module serial_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [WORD_SIZE*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic [WORD_SIZE-1:0]         ser_tx_data,
  output logic                         ser_new_tx_data,
  input  logic                         ser_tx_busy,
  output logic                         timeout_err,
  output logic [$clog2(NUM_REQ)-1:0]   timeout_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0]  TO_V     = SW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       gidx_q, gidx_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [SW-1:0]        stall_q, stall_d;
  logic [SW-1:0]        stall_inc;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic                 terr_q, terr_d;
  logic [IDW-1:0]       tid_q, tid_d;

  logic [WORD_SIZE-1:0] data_arr [NUM_REQ];
  logic [IDW:0]         pick;
  logic                 pick_vld;
  logic [IDW-1:0]       pick_idx;
  logic                 cur_req;
  logic                 cur_valid;
  logic                 cur_last;

  // Lowest k wins, so the scan starts at lst+1 and wraps.
  function automatic logic [IDW:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDW-1:0]     lst
  );
    logic [IDW:0] res;
    int           j;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(lst) + k) % NUM_REQ;
      if (r[IDW'(j)]) res = {1'b1, IDW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign pick      = rr_pick(req, last_q);
  assign pick_vld  = pick[IDW];
  assign pick_idx  = pick[IDW-1:0];
  assign cur_req   = req[gidx_q];
  assign cur_valid = req_valid[gidx_q];
  assign cur_last  = req_last[gidx_q];
  assign stall_inc = stall_q + SW'(1);

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    stall_d   = stall_q;
    grant_d   = grant_q;
    data_d    = '0;
    strobe_d  = 1'b0;
    terr_d    = 1'b0;
    tid_d     = tid_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d           = pick_idx;
          last_d           = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          stall_d          = '0;
          state_d          = ACTIVE;
        end
      end
      ACTIVE: begin
        // A dropped request never sees ready, so no byte is implied taken.
        req_ready[gidx_q] = ~ser_tx_busy & cur_req;
        if (!cur_req) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (cur_valid && !ser_tx_busy) begin
          data_d   = data_arr[gidx_q];
          strobe_d = 1'b1;
          stall_d  = '0;
          if (cur_last) begin
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end else if (!ser_tx_busy) begin
          if (TIMEOUT != 0 && stall_inc == TO_V) begin
            grant_d = '0;
            terr_d  = 1'b1;
            tid_d   = gidx_q;
            stall_d = '0;
            state_d = IDLE;
          end else begin
            stall_d = (&stall_q) ? stall_q : stall_inc;
          end
        end
      end
      GAP: begin
        state_d = ACTIVE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      last_q   <= LAST_RST;
      stall_q  <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      terr_q   <= 1'b0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      stall_q  <= stall_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      terr_q   <= terr_d;
      tid_q    <= tid_d;
    end
  end

  assign grant           = grant_q;
  assign ser_tx_data     = data_q;
  assign ser_new_tx_data = strobe_q;
  assign timeout_err     = terr_q;
  assign timeout_id      = tid_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_serial_tx_arbiter;

  localparam int NR = 4;
  localparam int WS = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req, req_valid, req_last;
  logic [NR-1:0] req_ready, grant;
  logic [WS*NR-1:0] req_data;
  logic [WS-1:0] ser_tx_data;
  logic          ser_new_tx_data;
  logic          ser_tx_busy;
  logic          timeout_err;
  logic [1:0]    timeout_id;

  always #5 clk = ~clk;

  serial_tx_arbiter #(
    .NUM_REQ  (NR),
    .WORD_SIZE(WS),
    .TIMEOUT  (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .grant          (grant),
    .ser_tx_data    (ser_tx_data),
    .ser_new_tx_data(ser_new_tx_data),
    .ser_tx_busy    (ser_tx_busy),
    .timeout_err    (timeout_err),
    .timeout_id     (timeout_id)
  );

  int n_chk;
  int n_fail;
  int cyc;

  int         m_own, m_ok, m_stall, m_last, m_tid;
  logic       m_strobe, m_terr;
  logic [7:0] m_data;

  logic [8:0]    pq [NR][$];
  int            vpct [NR];
  int            sc [$];
  logic [7:0]    sd [$];
  int            gc [$];
  int            gi [$];
  int            tc [$];
  logic [NR-1:0] gh [$];
  int            rcnt;
  logic [NR-1:0] prev_g;
  int            t;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_own    = -1;
    m_ok     = 0;
    m_stall  = 0;
    m_last   = NR - 1;
    m_tid    = 0;
    m_strobe = 1'b0;
    m_terr   = 1'b0;
    m_data   = '0;
  endtask

  task automatic clr_inputs();
    req         = '0;
    req_valid   = '0;
    req_last    = '0;
    req_data    = '0;
    ser_tx_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    for (int i = 0; i < NR; i++) begin
      pq[i].delete();
      vpct[i] = 100;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    sc.delete();
    sd.delete();
    gc.delete();
    gi.delete();
    tc.delete();
    gh.delete();
    rcnt   = 0;
    prev_g = '0;
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < NR; i++) begin
      e = (pq[i].size() != 0) ? pq[i][0] : 9'h0;
      req[i]       = (pq[i].size() != 0);
      req_valid[i] = req[i] && ($urandom_range(99) < vpct[i]);
      req_last[i]  = e[8];
      req_data[i*WS +: WS] = e[7:0];
    end
  endtask

  // Compare outputs against the model, then advance one clock.
  task automatic tick();
    logic [NR-1:0] eg, er, acc;
    int            j;
    bit            found;
    #1;
    eg = (m_own >= 0) ? NR'(1 << m_own) : '0;
    er = '0;
    if (m_own >= 0 && cyc >= m_ok && !ser_tx_busy && req[2'(m_own)])
      er[2'(m_own)] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    chk("ready", 32'(req_ready), 32'(er));
    chk("strobe", 32'(ser_new_tx_data), 32'(m_strobe));
    chk("data", 32'(ser_tx_data), 32'(m_data));
    chk("terr", 32'(timeout_err), 32'(m_terr));
    chk("tid", 32'(timeout_id), 32'(m_tid));
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    if (ser_new_tx_data) begin
      sc.push_back(cyc);
      sd.push_back(ser_tx_data);
    end
    if (grant != '0 && grant != prev_g) begin
      gc.push_back(cyc);
      gi.push_back(oh_idx(grant));
    end
    prev_g = grant;
    gh.push_back(grant);
    if (timeout_err) tc.push_back(cyc);
    if (req_ready != '0) rcnt++;

    acc      = er & req_valid;
    m_strobe = 1'b0;
    m_data   = '0;
    m_terr   = 1'b0;
    if (m_own < 0) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        j = (m_last + k) % NR;
        if (!found && req[2'(j)]) begin
          found = 1;
          m_own = j;
        end
      end
      if (found) begin
        m_last  = m_own;
        m_stall = 0;
        m_ok    = cyc + 1;
      end
    end else if (cyc >= m_ok) begin
      if (!req[2'(m_own)]) begin
        m_own = -1;
      end else if (acc[2'(m_own)]) begin
        m_strobe = 1'b1;
        m_data   = req_data[m_own*WS +: WS];
        m_stall  = 0;
        if (req_last[2'(m_own)]) m_own = -1;
        else m_ok = cyc + 2;
      end else if (!ser_tx_busy) begin
        m_stall++;
        if (m_stall == TO) begin
          m_terr  = 1'b1;
          m_tid   = m_own;
          pq[m_own].delete();
          m_own   = -1;
          m_stall = 0;
        end
      end
    end
    for (int i = 0; i < NR; i++)
      if (acc[i] && pq[i].size() != 0) void'(pq[i].pop_front());
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run1();
    drive();
    tick();
  endtask

  initial begin
    logic [7:0] eb [3];
    int         len;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    clr_inputs();
    @(negedge clk);

    // Single requester, 3-byte packet
    do_reset();
    eb[0] = 8'hA1;
    eb[1] = 8'hB2;
    eb[2] = 8'hC3;
    pq[0].push_back({1'b0, eb[0]});
    pq[0].push_back({1'b0, eb[1]});
    pq[0].push_back({1'b1, eb[2]});
    t = cyc;
    repeat (10) run1();
    chk("t1_nstrobe", 32'(sc.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_scyc", 32'(k < sc.size() ? sc[k] : -1), 32'(t + 2 + 2*k));
      chk("t1_sdat", 32'(k < sd.size() ? sd[k] : 8'h00), 32'(eb[k]));
    end
    chk("t1_g5", 32'(gh[t+5]), 32'h1);
    chk("t1_g6", 32'(gh[t+6]), 32'h0);

    // All requesters, continuous 1-byte packets
    do_reset();
    for (int i = 0; i < NR; i++) pq[i].push_back({1'b1, 8'(8'h40 + i)});
    repeat (20) begin
      run1();
      for (int i = 0; i < NR; i++)
        if (pq[i].size() == 0) pq[i].push_back({1'b1, 8'(8'h40 + i)});
    end
    for (int k = 0; k < 5; k++) begin
      chk("t2_gidx", 32'(k < gi.size() ? gi[k] : -1), 32'(k % NR));
      chk("t2_gcyc", 32'(k < gc.size() ? gc[k] : -1), 32'(1 + 2*k));
    end

    // Busy held high for 50+ cycles with valid asserted
    do_reset();
    ser_tx_busy = 1'b1;
    pq[1].push_back({1'b1, 8'h5A});
    t = cyc;
    repeat (51) run1();
    chk("t3_grant", 32'(gh[t+1]), 32'h2);
    chk("t3_rdy", 32'(rcnt), 32'd0);
    chk("t3_nostrobe", 32'(sc.size()), 32'd0);
    chk("t3_noterr", 32'(tc.size()), 32'd0);
    ser_tx_busy = 1'b0;
    t = cyc;
    repeat (4) run1();
    chk("t3_nstrobe", 32'(sc.size()), 32'd1);
    chk("t3_scyc", 32'(sc.size() > 0 ? sc[0] : -1), 32'(t + 1));
    chk("t3_sdat", 32'(sd.size() > 0 ? sd[0] : 8'h00), 32'h5A);

    // Timeout on requester 2, requester 3 next
    do_reset();
    vpct[2] = 0;
    pq[2].push_back({1'b1, 8'h62});
    pq[3].push_back({1'b1, 8'h73});
    t = cyc;
    repeat (14) run1();
    chk("t4_nterr", 32'(tc.size()), 32'd1);
    chk("t4_tcyc", 32'(tc.size() > 0 ? tc[0] : -1), 32'(t + 9));
    chk("t4_tid", 32'(timeout_id), 32'd2);
    chk("t4_g9", 32'(gh[t+9]), 32'h0);
    chk("t4_next", 32'(gi.size() > 1 ? gi[1] : -1), 32'd3);
    chk("t4_ncyc", 32'(gc.size() > 1 ? gc[1] : -1), 32'(t + 10));

    // Requester 0 aborts after one byte
    do_reset();
    pq[0].push_back({1'b0, 8'h10});
    pq[0].push_back({1'b0, 8'h11});
    pq[0].push_back({1'b1, 8'h12});
    pq[1].push_back({1'b1, 8'h51});
    t = cyc;
    repeat (12) begin
      if (cyc == t + 3) pq[0].delete();
      run1();
    end
    chk("t5_nstrobe", 32'(sc.size()), 32'd2);
    chk("t5_s0", 32'(sd.size() > 0 ? sd[0] : 8'h00), 32'h10);
    chk("t5_s1", 32'(sd.size() > 1 ? sd[1] : 8'h00), 32'h51);
    chk("t5_s1cyc", 32'(sc.size() > 1 ? sc[1] : -1), 32'(t + 6));
    chk("t5_g1", 32'(gi.size() > 1 ? gi[1] : -1), 32'd1);
    chk("t5_g1cyc", 32'(gc.size() > 1 ? gc[1] : -1), 32'(t + 5));

    // Async reset between edges with a strobe pending
    do_reset();
    pq[0].push_back({1'b1, 8'h99});
    run1();
    drive();
    #1;
    chk("t6_pre_rdy", 32'(req_ready), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_rdy", 32'(req_ready), 32'h0);
    chk("t6_strobe", 32'(ser_new_tx_data), 32'h0);
    chk("t6_data", 32'(ser_tx_data), 32'h0);
    chk("t6_terr", 32'(timeout_err), 32'h0);
    @(posedge clk);
    #1;
    chk("t6_hold", 32'(ser_new_tx_data), 32'h0);
    @(negedge clk);
    do_reset();
    repeat (6) run1();
    chk("t6_nostrobe", 32'(sc.size()), 32'd0);

    // Random traffic against the model
    do_reset();
    vpct[0] = 70;
    vpct[1] = 50;
    vpct[2] = 30;
    vpct[3] = 10;
    repeat (3000) begin
      ser_tx_busy = ($urandom_range(99) < 25);
      for (int i = 0; i < NR; i++) begin
        if (pq[i].size() == 0) begin
          if ($urandom_range(99) < 6) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++)
              pq[i].push_back({1'(b == len - 1), 8'($urandom)});
          end
        end else if ($urandom_range(999) < 4) begin
          pq[i].delete();
        end
      end
      run1();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
